// File: rtl/dcache_store_port_pkg.sv
// Shared encodings for the dcache store-drain port: memory access types,
// store sizes and the write-sequencing FSM states.
package dcache_store_port_pkg;

  // Memory access type carried with each store
  localparam logic [1:0] MAT_UC = 2'b00;
  localparam logic [1:0] MAT_CC = 2'b01;

  // Store size sideband; 2'b11 is handled like a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int STRB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESOLVE,
    ST_MEMWR,
    ST_DONE
  } sp_state_e;

  // Only MAT_CC goes through the cache; every other code is written uncached
  function automatic logic is_cached(input logic [1:0] mat);
    return (mat == MAT_CC);
  endfunction

endpackage

// File: rtl/dcache_store_port_align.sv
// Combinational lane alignment of a right-aligned store: turns size and the
// low address bits into byte enables and lane-positioned write data.
module store_lane_align
  import dcache_store_port_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DW-1:0]     data_i,
  output logic [STRB_W-1:0] strb_o,
  output logic [DW-1:0]     data_o
);

  // Byte/half are shifted into their lane; word (and size 11) pass through
  always_comb begin
    strb_o = 4'b1111;
    data_o = data_i;
    case (size_i)
      SZ_BYTE: begin
        strb_o = 4'b0001 << addr_lo_i;
        data_o = DW'(data_i[7:0]) << {addr_lo_i, 3'b000};
      end
      SZ_HALF: begin
        // A[0] does not participate: a half always sits in lanes 0-1 or 2-3
        strb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o = DW'(data_i[15:0]) << {addr_lo_i[1], 4'b0000};
      end
      default: begin
        strb_o = 4'b1111;
        data_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/dcache_store_port.sv
// Dcache responder for the store-buffer drain interface. Accepted stores are
// lane-aligned, queued in order and written one at a time: cached stores do
// a tag lookup and write the data array on hit (no allocate on miss), the
// rest go out on the memory write bus. The entry pointer is handed back to
// the store buffer once the write is globally done.
module dcache_store_port
  import dcache_store_port_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              SbToDcdAble,
  input  logic [1:0]        SbToDcdAMat,
  input  logic [2:0]        SbToDcdAPtr,
  input  logic [AW-1:0]     SbToDcdAPhyAddr,
  input  logic [DW-1:0]     SbToDcdAPhyDate,
  input  logic [1:0]        SbToDcdASize,
  output logic              DcdToSbSuccess,
  output logic              DcdToSbBackAble,
  output logic [2:0]        DcdToSbBackPtr,
  output logic              TagReq,
  output logic [AW-1:0]     TagAddr,
  input  logic              TagHit,
  output logic              CacheWrAble,
  output logic [AW-1:0]     CacheWrAddr,
  output logic [DW-1:0]     CacheWrDate,
  output logic [STRB_W-1:0] CacheWrStrb,
  output logic              MemWrReq,
  output logic [AW-1:0]     MemWrAddr,
  output logic [DW-1:0]     MemWrDate,
  output logic [STRB_W-1:0] MemWrStrb,
  input  logic              MemWrAck,
  output logic              PortEmpty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic [1:0]        mat;
    logic [2:0]        ptr;
    logic [AW-1:0]     addr;   // word aligned
    logic [DW-1:0]     data;   // lane aligned
    logic [STRB_W-1:0] strb;
  } sq_entry_t;

  // ---------------------------------------------------------------------------
  // Enqueue path
  // ---------------------------------------------------------------------------
  logic [STRB_W-1:0] al_strb;
  logic [DW-1:0]     al_data;
  sq_entry_t         new_ent;

  store_lane_align #(.DW(DW)) u_align (
    .size_i    (SbToDcdASize),
    .addr_lo_i (SbToDcdAPhyAddr[1:0]),
    .data_i    (SbToDcdAPhyDate),
    .strb_o    (al_strb),
    .data_o    (al_data)
  );

  always_comb begin
    new_ent.mat  = SbToDcdAMat;
    new_ent.ptr  = SbToDcdAPtr;
    new_ent.addr = {SbToDcdAPhyAddr[AW-1:2], 2'b00};
    new_ent.data = al_data;
    new_ent.strb = al_strb;
  end

  // ---------------------------------------------------------------------------
  // Pending-store queue; the extra pointer MSB separates full from empty
  // ---------------------------------------------------------------------------
  sq_entry_t   q_mem_q [QDEPTH];
  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        full, empty, enq, pop;
  sq_entry_t   head;
  sp_state_e   state_q;

  assign empty = (wr_q == rd_q);
  assign full  = ((wr_q ^ rd_q) == {1'b1, {PW{1'b0}}});
  assign pop   = (state_q == ST_DONE);
  assign head  = q_mem_q[rd_q[PW-1:0]];

  // A full queue still accepts in the cycle its head retires
  assign enq            = SbToDcdAble & ~Rest & (~full | pop);
  assign DcdToSbSuccess = enq;

  always_comb begin
    wr_d = wr_q + (PW+1)'(enq);
    rd_d = rd_q + (PW+1)'(pop);
  end

  // Queue pointers
  always_ff @(posedge Clk) begin
    if (Rest) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers
  always_ff @(posedge Clk) begin
    if (enq) q_mem_q[wr_q[PW-1:0]] <= new_ent;
  end

  // ---------------------------------------------------------------------------
  // Write sequencer, serving the queue head only
  // ---------------------------------------------------------------------------
  logic              tag_req_q;
  logic [AW-1:0]     tag_addr_q;
  logic              cwr_q;
  logic [AW-1:0]     cwr_addr_q;
  logic [DW-1:0]     cwr_data_q;
  logic [STRB_W-1:0] cwr_strb_q;
  logic              mwr_q;
  logic [AW-1:0]     mwr_addr_q;
  logic [DW-1:0]     mwr_data_q;
  logic [STRB_W-1:0] mwr_strb_q;
  logic              back_q;
  logic [2:0]        back_ptr_q;

  // State plus registered outputs; single-cycle strobes default low each cycle
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q    <= ST_IDLE;
      tag_req_q  <= 1'b0;
      tag_addr_q <= '0;
      cwr_q      <= 1'b0;
      cwr_addr_q <= '0;
      cwr_data_q <= '0;
      cwr_strb_q <= '0;
      mwr_q      <= 1'b0;
      mwr_addr_q <= '0;
      mwr_data_q <= '0;
      mwr_strb_q <= '0;
      back_q     <= 1'b0;
      back_ptr_q <= '0;
    end else begin
      tag_req_q  <= 1'b0;
      tag_addr_q <= '0;
      cwr_q      <= 1'b0;
      cwr_addr_q <= '0;
      cwr_data_q <= '0;
      cwr_strb_q <= '0;
      back_q     <= 1'b0;
      back_ptr_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (is_cached(head.mat)) begin
              state_q    <= ST_LOOKUP;
              tag_req_q  <= 1'b1;
              tag_addr_q <= head.addr;
            end else begin
              state_q    <= ST_MEMWR;
              mwr_q      <= 1'b1;
              mwr_addr_q <= head.addr;
              mwr_data_q <= head.data;
              mwr_strb_q <= head.strb;
            end
          end
        end
        ST_LOOKUP: begin
          // TagReq is high for this one cycle; the hit comes back next cycle
          state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (TagHit) begin
            state_q    <= ST_DONE;
            cwr_q      <= 1'b1;
            cwr_addr_q <= head.addr;
            cwr_data_q <= head.data;
            cwr_strb_q <= head.strb;
            back_q     <= 1'b1;
            back_ptr_q <= head.ptr;
          end else begin
            // No allocate on miss: the store goes straight to memory
            state_q    <= ST_MEMWR;
            mwr_q      <= 1'b1;
            mwr_addr_q <= head.addr;
            mwr_data_q <= head.data;
            mwr_strb_q <= head.strb;
          end
        end
        ST_MEMWR: begin
          if (MemWrAck) begin
            state_q    <= ST_DONE;
            mwr_q      <= 1'b0;
            mwr_addr_q <= '0;
            mwr_data_q <= '0;
            mwr_strb_q <= '0;
            back_q     <= 1'b1;
            back_ptr_q <= head.ptr;
          end
        end
        ST_DONE: begin
          // BackAble is visible this cycle; the head pops at this edge
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TagReq          = tag_req_q;
  assign TagAddr         = tag_addr_q;
  assign CacheWrAble     = cwr_q;
  assign CacheWrAddr     = cwr_addr_q;
  assign CacheWrDate     = cwr_data_q;
  assign CacheWrStrb     = cwr_strb_q;
  assign MemWrReq        = mwr_q;
  assign MemWrAddr       = mwr_addr_q;
  assign MemWrDate       = mwr_data_q;
  assign MemWrStrb       = mwr_strb_q;
  assign DcdToSbBackAble = back_q;
  assign DcdToSbBackPtr  = back_ptr_q;
  assign PortEmpty       = empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_dcache_store_port.sv
// Directed bench for dcache_store_port: reset values, uncached/cached
// paths with lane alignment, latency, backpressure ordering and reset abort.
module tb_dcache_store_port;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        SbToDcdAble;
  logic [1:0]  SbToDcdAMat;
  logic [2:0]  SbToDcdAPtr;
  logic [31:0] SbToDcdAPhyAddr;
  logic [31:0] SbToDcdAPhyDate;
  logic [1:0]  SbToDcdASize;
  logic        DcdToSbSuccess;
  logic        DcdToSbBackAble;
  logic [2:0]  DcdToSbBackPtr;
  logic        TagReq;
  logic [31:0] TagAddr;
  logic        TagHit;
  logic        CacheWrAble;
  logic [31:0] CacheWrAddr;
  logic [31:0] CacheWrDate;
  logic [3:0]  CacheWrStrb;
  logic        MemWrReq;
  logic [31:0] MemWrAddr;
  logic [31:0] MemWrDate;
  logic [3:0]  MemWrStrb;
  logic        MemWrAck;
  logic        PortEmpty;

  dcache_store_port #(.QDEPTH(2), .AW(32), .DW(32)) dut (
    .Clk             (Clk),
    .Rest            (Rest),
    .SbToDcdAble     (SbToDcdAble),
    .SbToDcdAMat     (SbToDcdAMat),
    .SbToDcdAPtr     (SbToDcdAPtr),
    .SbToDcdAPhyAddr (SbToDcdAPhyAddr),
    .SbToDcdAPhyDate (SbToDcdAPhyDate),
    .SbToDcdASize    (SbToDcdASize),
    .DcdToSbSuccess  (DcdToSbSuccess),
    .DcdToSbBackAble (DcdToSbBackAble),
    .DcdToSbBackPtr  (DcdToSbBackPtr),
    .TagReq          (TagReq),
    .TagAddr         (TagAddr),
    .TagHit          (TagHit),
    .CacheWrAble     (CacheWrAble),
    .CacheWrAddr     (CacheWrAddr),
    .CacheWrDate     (CacheWrDate),
    .CacheWrStrb     (CacheWrStrb),
    .MemWrReq        (MemWrReq),
    .MemWrAddr       (MemWrAddr),
    .MemWrDate       (MemWrDate),
    .MemWrStrb       (MemWrStrb),
    .MemWrAck        (MemWrAck),
    .PortEmpty       (PortEmpty)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Completion log, sampled mid-cycle
  logic [2:0] back_log[$];
  always @(negedge Clk) if (DcdToSbBackAble) back_log.push_back(DcdToSbBackPtr);

  task automatic drive(input logic [1:0] mat, input logic [2:0] ptr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    SbToDcdAble     = 1'b1;
    SbToDcdAMat     = mat;
    SbToDcdAPtr     = ptr;
    SbToDcdAPhyAddr = addr;
    SbToDcdAPhyDate = data;
    SbToDcdASize    = size;
  endtask

  // One store from an idle port; latency counts edges from the accept edge
  task automatic serve(input string tag, input logic [1:0] mat, input logic [2:0] ptr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                       input logic hit, input int exp_lat, input logic exp_mem,
                       input logic [3:0] exp_strb, input logic [31:0] exp_addr,
                       input logic [31:0] exp_data);
    int          lat;
    logic        mem_seen, cache_seen;
    logic [3:0]  strb;
    logic [31:0] wa, wd;
    logic [2:0]  bptr;
    TagHit   = hit;
    MemWrAck = 1'b1;
    drive(mat, ptr, addr, data, size);
    #1;
    check({tag, "_succ"}, {31'd0, DcdToSbSuccess}, 32'd1);
    lat = 0; mem_seen = 0; cache_seen = 0; strb = 0; wa = 0; wd = 0; bptr = 0;
    while (lat < 20) begin
      tick();
      lat++;
      SbToDcdAble = 1'b0;
      if (MemWrReq) begin
        mem_seen = 1; strb = MemWrStrb; wa = MemWrAddr; wd = MemWrDate;
      end
      if (CacheWrAble) begin
        cache_seen = 1; strb = CacheWrStrb; wa = CacheWrAddr; wd = CacheWrDate;
      end
      if (DcdToSbBackAble) begin
        bptr = DcdToSbBackPtr;
        break;
      end
    end
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_bptr"},  {29'd0, bptr}, {29'd0, ptr});
    check({tag, "_mem"},   {31'd0, mem_seen}, {31'd0, exp_mem});
    check({tag, "_cache"}, {31'd0, cache_seen}, {31'd0, ~exp_mem});
    check({tag, "_strb"},  {28'd0, strb}, {28'd0, exp_strb});
    check({tag, "_addr"},  wa, exp_addr);
    check({tag, "_data"},  wd, exp_data);
    tick();
    check({tag, "_back_lo"}, {28'd0, DcdToSbBackAble, DcdToSbBackPtr}, 32'd0);
    check({tag, "_empty"},   {31'd0, PortEmpty}, 32'd1);
  endtask

  int n_log;
  int guard;

  initial begin
    Rest = 1'b1; TagHit = 1'b0; MemWrAck = 1'b0;
    drive(2'b00, 3'd7, 32'h0, 32'h0, 2'b10);
    tick();
    tick();
    check("rst_succ_gated", {31'd0, DcdToSbSuccess}, 32'd0);
    SbToDcdAble = 1'b0;
    Rest = 1'b0;
    tick();
    check("rst_empty", {31'd0, PortEmpty}, 32'd1);
    check("rst_strobes", {27'd0, TagReq, CacheWrAble, MemWrReq, DcdToSbBackAble, DcdToSbSuccess}, 32'd0);
    check("rst_ptr", {29'd0, DcdToSbBackPtr}, 32'd0);

    // mat ptr addr data size hit lat mem strb addr data
    serve("uc_word",  2'b00, 3'd3, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, 3, 1'b1,
          4'b1111, 32'h1000_0004, 32'hDEAD_BEEF);
    serve("cc_byte_hit", 2'b01, 3'd2, 32'h8000_0003, 32'h0000_00A5, 2'b00, 1'b1, 4, 1'b0,
          4'b1000, 32'h8000_0000, 32'hA500_0000);
    serve("cc_half_miss", 2'b01, 3'd4, 32'h8000_0002, 32'h0000_1234, 2'b01, 1'b0, 5, 1'b1,
          4'b1100, 32'h8000_0000, 32'h1234_0000);
    serve("uc_half_lo", 2'b00, 3'd5, 32'h2000_0001, 32'h0000_BEEF, 2'b01, 1'b0, 3, 1'b1,
          4'b0011, 32'h2000_0000, 32'h0000_BEEF);
    serve("mat10_byte1", 2'b10, 3'd6, 32'h1000_0005, 32'h0000_003C, 2'b00, 1'b1, 3, 1'b1,
          4'b0010, 32'h1000_0004, 32'h0000_3C00);
    serve("cc_size11", 2'b01, 3'd7, 32'h4000_000B, 32'h0123_4567, 2'b11, 1'b1, 4, 1'b0,
          4'b1111, 32'h4000_0008, 32'h0123_4567);

    // Backpressure: ptr 1,2 fill the queue, ptr 3 waits for a slot
    back_log.delete();
    MemWrAck = 1'b0;
    drive(2'b00, 3'd1, 32'h3000_0000, 32'h1111_1111, 2'b10);
    #1;
    check("bp_succ1", {31'd0, DcdToSbSuccess}, 32'd1);
    tick();
    drive(2'b00, 3'd2, 32'h3000_0004, 32'h2222_2222, 2'b10);
    #1;
    check("bp_succ2", {31'd0, DcdToSbSuccess}, 32'd1);
    tick();
    drive(2'b00, 3'd3, 32'h3000_0008, 32'h3333_3333, 2'b10);
    #1;
    repeat (5) begin
      check("bp_stall", {31'd0, DcdToSbSuccess}, 32'd0);
      check("bp_hold_addr", MemWrReq ? MemWrAddr : 32'hFFFF_FFFF, 32'h3000_0000);
      tick();
    end
    MemWrAck = 1'b1;
    #1;
    check("bp_stall_ack", {31'd0, DcdToSbSuccess}, 32'd0);
    tick();
    check("enq_deq_full", {31'd0, DcdToSbSuccess}, 32'd1);
    check("bp_back1", {28'd0, DcdToSbBackAble, DcdToSbBackPtr}, {28'd0, 1'b1, 3'd1});
    tick();
    drive(2'b00, 3'd4, 32'h3000_000C, 32'h4444_4444, 2'b10);
    #1;
    check("still_full", {31'd0, DcdToSbSuccess}, 32'd0);
    SbToDcdAble = 1'b0;
    guard = 0;
    while (back_log.size() < 3 && guard < 40) begin
      tick();
      guard++;
    end
    check("bp_count", back_log.size(), 3);
    if (back_log.size() >= 3) begin
      check("bp_order0", {29'd0, back_log[0]}, 32'd1);
      check("bp_order1", {29'd0, back_log[1]}, 32'd2);
      check("bp_order2", {29'd0, back_log[2]}, 32'd3);
    end
    tick();
    tick();
    check("bp_empty", {31'd0, PortEmpty}, 32'd1);

    // Reset while a memory write is outstanding
    MemWrAck = 1'b0;
    drive(2'b00, 3'd5, 32'h5000_0000, 32'h5555_5555, 2'b10);
    tick();
    SbToDcdAble = 1'b0;
    tick();
    check("rmw_req", {31'd0, MemWrReq}, 32'd1);
    n_log = back_log.size();
    Rest = 1'b1;
    tick();
    Rest = 1'b0;
    check("rmw_req_drop", {31'd0, MemWrReq}, 32'd0);
    check("rmw_addr_clr", MemWrAddr, 32'd0);
    check("rmw_empty", {31'd0, PortEmpty}, 32'd1);
    MemWrAck = 1'b1;
    repeat (4) tick();
    check("rmw_no_back", back_log.size(), n_log);
    check("rmw_idle", {31'd0, MemWrReq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
